// File: rtl/scan_decoder_pkg.sv
// Shared mode encoding, default parameters and a width helper for the scan decoder.
package scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_SEL_W = 3;
  localparam int DEF_DWELL = 4;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_decoder_timer.sv
// scan_timer: dwell counter cycling 0..DWELL-1; done marks the enabled cycle at DWELL-1.
module scan_timer
  import scan_decoder_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  assign done = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= done ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: one-hot channel strobe with direct select and timed auto-scan.
// Optional macro SCAN_DECODER_BLANK_EN inserts one blank cycle on each scan advance.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int N_OUT = 2 ** SEL_W,
  parameter int DWELL = DEF_DWELL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             oe,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             hold,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_OUT'(1) << i;
  endfunction

  logic [N_OUT-1:0] r_out;
  logic [SEL_W-1:0] r_idx;
  logic             r_wrap;

  mode_e            w_mode;
  logic             w_load;
  logic             w_scan;
  logic             w_clear;
  logic             w_en;
  logic             w_adv;
  logic             w_last;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [N_OUT-1:0] w_out_nxt;

  assign w_mode = mode_e'(mode);
  assign w_scan = (w_mode == MODE_SCAN);
  // Out-of-range selects are dropped entirely, so they never disturb the dwell either.
  assign w_load = sel_valid && ({1'b0, sel} < N_LIM);
  // Direct mode pins the counter at 0 so entering scan starts a full dwell.
  assign w_clear = !w_scan || w_load;
  assign w_en    = w_scan && !hold && !w_load;
  assign w_last  = (r_idx == LAST_IDX);

  scan_timer #(.DWELL(DWELL)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_en),
    .done   (w_adv)
  );

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_load) begin
      w_idx_nxt = sel;
    end else if (w_adv) begin
      w_idx_nxt = w_last ? '0 : r_idx + SEL_W'(1);
    end
  end

  always_comb begin
    w_out_nxt = oe ? onehot(w_idx_nxt) : '0;
`ifdef SCAN_DECODER_BLANK_EN
    if (w_adv) begin
      w_out_nxt = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_out  <= w_out_nxt;
      r_wrap <= w_adv && w_last;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3, select/index width; SHALL be >= 1.
REQ-002 Parameter N_OUT, default 2**SEL_W, one-hot output count; SHALL satisfy 2 <= N_OUT <= 2**SEL_W.
REQ-003 Parameter DWELL, default 4, cycles per channel in scan mode; SHALL be >= 1.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 mode  in  1  0 = direct select, 1 = auto-scan.
REQ-007 oe  in  1  output enable; 0 forces out to zero.
REQ-008 sel_valid  in  1  qualifies sel for one cycle.
REQ-009 sel  in  SEL_W  requested channel index.
REQ-010 hold  in  1  freezes scan progress.
REQ-011 out  out  N_OUT  registered one-hot strobe (bit i = channel i).
REQ-012 idx  out  SEL_W  registered current channel index.
REQ-013 wrap  out  1  one-cycle pulse on scan wrap-around.

Function
REQ-014 out SHALL equal onehot(idx) when oe was 1 at the updating edge, else all zero; at most one bit of out SHALL ever be set.
REQ-015 Direct mode: sel_valid=1 with sel < N_OUT SHALL load idx=sel; out SHALL show onehot(sel) after that same edge (latency 1).
REQ-016 sel_valid=1 with sel >= N_OUT SHALL be ignored; idx and out unchanged.
REQ-017 Scan mode: dwell counter SHALL count 0..DWELL-1; at DWELL-1 with hold=0, idx SHALL advance by 1 and counter return to 0.
REQ-018 Advance from idx=N_OUT-1 SHALL wrap to 0 and assert wrap for exactly that one cycle; wrap SHALL be 0 otherwise and always 0 in direct mode.
REQ-019 hold=1 SHALL freeze counter and idx; release SHALL resume with the remaining dwell count.
REQ-020 Scan mode sel_valid (valid sel) SHALL load idx=sel and clear counter; it SHALL take priority over advance and hold, and SHALL NOT pulse wrap.
REQ-021 Direct mode SHALL keep the counter at 0; a mode 0->1 transition SHALL start a full dwell on the retained idx.
REQ-022 oe=0 SHALL NOT stop scanning; on oe return out SHALL show onehot(current idx) after one edge.

Reset
REQ-023 rst=1 SHALL force idx=0, counter=0, out=0, wrap=0, overriding all other inputs.
REQ-024 rst asserted mid-dwell SHALL discard progress; first edge after release with oe=1 SHALL give out=onehot(0).

Configuration
REQ-025 Macro SCAN_DECODER_BLANK_EN defined: each scan advance SHALL drive out=0 for one cycle (break-before-make) before onehot(new idx); idx updates on the advance edge; direct-mode loads are unaffected.
REQ-026 Macro undefined: out SHALL move directly to the new channel on the advance edge.

Structure
REQ-027 Package scan_decoder_pkg SHALL hold the mode encoding (MODE_DIRECT=0, MODE_SCAN=1) and default parameter constants.
REQ-028 Dwell counter SHALL be a sub-module scan_timer (inputs clear, enable; output done).

Verification
REQ-029 rst high 2 cycles -> out=0, idx=0, wrap=0; release, oe=1, mode=0 -> out=8'h01 after one edge.
REQ-030 Direct, sel=5 valid one cycle -> out=8'h20, idx=5; sel=3 -> 8'h08; sel_valid=0 with sel=7 -> no change.
REQ-031 Scan, DWELL=4 -> out 01,02,04..80 each 4 cycles, then 01 with wrap=1 for one cycle.
REQ-032 hold high 10 cycles after 2 dwell cycles -> out frozen; released -> advance after 2 more cycles.
REQ-033 oe low 6 cycles during scan -> out=0, idx advances; oe high -> out=onehot(idx) next edge.
REQ-034 N_OUT=5: sel=6 ignored; scan wraps 4->0; with SCAN_DECODER_BLANK_EN each advance shows one 00 cycle.
